// File: rtl/multimode_store.sv
// Single-port storage engine: FIFO, LIFO or overwrite ring buffer, mode chosen at run time.
// A change of mode flushes the contents on the edge where the new mode is first seen.
module multimode_store #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   mode,
  input  logic                         enable,
  input  logic [DATA_W-1:0]            din,
  input  logic                         push,
  input  logic                         pop,
  output logic [DATA_W-1:0]            dout,
  output logic                         dout_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_empty,
  output logic                         almost_full,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] M_FIFO = 2'b00;
  localparam logic [1:0] M_LIFO = 2'b01;
  localparam logic [1:0] M_BUF  = 2'b10;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [PTR_W-1:0]  wr_idx, rd_idx, top_idx, push_idx;
  logic [CNT_W-1:0]  count_n;
  logic [1:0]        mode_q;
  logic              do_wr, do_rd, ovf_n, udf_n, overwrite;

  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(DEPTH));
  assign almost_empty = (count <= CNT_W'(AE_LEVEL));
  assign almost_full  = (count >= CNT_W'(AF_LEVEL));

  // Stack indices: truncation makes count==DEPTH map its top to DEPTH-1.
  assign push_idx = count[PTR_W-1:0];
  assign top_idx  = count[PTR_W-1:0] - PTR_W'(1);

  always_comb begin
    do_wr     = 1'b0;
    do_rd     = 1'b0;
    overwrite = 1'b0;
    ovf_n     = 1'b0;
    udf_n     = 1'b0;
    wr_idx    = wr_ptr;
    rd_idx    = rd_ptr;
    wr_ptr_n  = wr_ptr;
    rd_ptr_n  = rd_ptr;
    count_n   = count;
    if (mode != mode_q) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
    end else if (enable) begin
      case (mode)
        M_FIFO, M_BUF: begin
          udf_n = pop && empty;
          do_rd = pop && !empty;
          if (push) begin
            if (!full || do_rd) begin
              do_wr = 1'b1;
            end else if (mode == M_BUF) begin
              do_wr     = 1'b1;
              overwrite = 1'b1;
            end else begin
              ovf_n = 1'b1;
            end
          end
          if (do_wr) wr_ptr_n = wr_ptr + PTR_W'(1);
          if (do_rd || overwrite) rd_ptr_n = rd_ptr + PTR_W'(1);
          if (do_wr && !do_rd && !overwrite) count_n = count + CNT_W'(1);
          else if (do_rd && !do_wr) count_n = count - CNT_W'(1);
        end
        M_LIFO: begin
          udf_n = pop && empty;
          if (pop && !empty) begin
            do_rd  = 1'b1;
            rd_idx = top_idx;
            if (push) begin
              // Replace the top in place: old top goes out, din becomes the new top.
              do_wr  = 1'b1;
              wr_idx = top_idx;
            end else begin
              count_n = count - CNT_W'(1);
            end
          end else if (push) begin
            if (!full) begin
              do_wr   = 1'b1;
              wr_idx  = push_idx;
              count_n = count + CNT_W'(1);
            end else begin
              ovf_n = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      mode_q     <= mode;
    end else begin
      count      <= count_n;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      mode_q     <= mode;
      dout_valid <= do_rd;
      overflow   <= ovf_n;
      underflow  <= udf_n;
      if (do_rd) dout <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_wr) mem[wr_idx] <= din;
  end

endmodule

// File: tb/tb_multimode_store.sv
// Bench for multimode_store: queue-based reference model feeds a scoreboard of expected read data.
module tb_multimode_store;

  logic       clk = 1'b0;
  logic       reset, enable, push, pop;
  logic [1:0] mode;
  logic [7:0] din, dout;
  logic [4:0] count;
  logic       dout_valid, empty, full, almost_empty, almost_full, overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];

  multimode_store #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .mode(mode), .enable(enable), .din(din),
    .push(push), .pop(pop), .dout(dout), .dout_valid(dout_valid), .count(count),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One enabled operation with a stable mode; the model predicts flags and read data.
  task automatic step(input string tag, input bit p, input bit q, input logic [7:0] d);
    int  n;
    bit  e_ovf, e_udf, rd;
    n = model_q.size();
    e_ovf = 0; e_udf = 0; rd = 0;
    push = p; pop = q; din = d;
    if (q && n == 0) e_udf = 1;
    if (q && n > 0) begin
      rd = 1;
      if (mode == 2'b01) exp_q.push_back(model_q.pop_back());
      else               exp_q.push_back(model_q.pop_front());
    end
    if (p) begin
      if (n < 16 || rd) model_q.push_back(d);
      else if (mode == 2'b10) begin
        void'(model_q.pop_front());
        model_q.push_back(d);
      end else e_ovf = 1;
    end
    tick();
    push = 0; pop = 0;
    n = model_q.size();
    check({tag, "_count"}, 32'(count), 32'(n));
    check({tag, "_ovf"}, 32'(overflow), 32'(e_ovf));
    check({tag, "_udf"}, 32'(underflow), 32'(e_udf));
    check({tag, "_vld"}, 32'(dout_valid), 32'(rd));
    check({tag, "_flags"}, {28'd0, empty, full, almost_empty, almost_full},
          {28'd0, n == 0, n == 16, n <= 2, n >= 14});
    if (dout_valid) begin
      if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
      else check({tag, "_dout"}, 32'(dout), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic change_mode(input logic [1:0] m, input bit p);
    mode = m; push = p; pop = 0; din = 8'h77;
    tick();
    push = 0;
    model_q.delete();
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_ovf", 32'(overflow), 32'd0);
    check("flush_vld", 32'(dout_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] held;
    reset = 1; mode = 2'b00; enable = 1; push = 0; pop = 0; din = 0;
    tick(); tick();
    reset = 0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_vld", 32'(dout_valid), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_pulses", {30'd0, overflow, underflow}, 32'd0);

    // FIFO order, overflow, underflow
    for (int i = 1; i <= 16; i++) step("t1_push", 1, 0, 8'(i));
    step("t1_ovf", 1, 0, 8'd17);
    for (int i = 1; i <= 16; i++) step("t1_pop", 0, 1, 8'd0);
    step("t1_udf", 0, 1, 8'd0);

    // Simultaneous ops at limits
    step("t4_empty_pp", 1, 1, 8'd55);
    for (int i = 2; i <= 16; i++) step("t4_fill", 1, 0, 8'(100 + i));
    step("t4_full_pp", 1, 1, 8'd99);
    for (int i = 0; i < 11; i++) step("t4_drain", 0, 1, 8'd0);

    // Mode change with a push on the switching edge
    check("t5_pre_count", 32'(count), 32'd5);
    change_mode(2'b01, 1);

    // LIFO order and replace-top
    step("t2_push", 1, 0, 8'hA1);
    step("t2_push", 1, 0, 8'hB2);
    step("t2_push", 1, 0, 8'hC3);
    for (int i = 0; i < 3; i++) step("t2_pop", 0, 1, 8'd0);
    step("t2_pushd", 1, 0, 8'hD4);
    step("t2_pp", 1, 1, 8'hE5);
    step("t2_last", 0, 1, 8'd0);
    step("t2_udf", 0, 1, 8'd0);

    // Overwrite ring buffer
    change_mode(2'b10, 0);
    for (int i = 1; i <= 20; i++) step("t3_push", 1, 0, 8'(i));
    for (int i = 0; i < 16; i++) step("t3_pop", 0, 1, 8'd0);

    // Gating and reset
    change_mode(2'b00, 0);
    for (int i = 1; i <= 8; i++) step("t6_fill", 1, 0, 8'(40 + i));
    step("t6_pop", 0, 1, 8'd0);
    held = dout;
    enable = 0;
    for (int i = 0; i < 4; i++) begin
      push = 1; pop = 1; din = 8'hEE;
      tick();
      check("t6_gate_count", 32'(count), 32'd7);
      check("t6_gate_dout", 32'(dout), 32'(held));
      check("t6_gate_pulses", {29'd0, dout_valid, overflow, underflow}, 32'd0);
    end
    push = 0; pop = 0; enable = 1;
    reset = 1;
    tick();
    reset = 0;
    model_q.delete();
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_dout", 32'(dout), 32'd0);
    check("t6_rst_empty", 32'(empty), 32'd1);
    step("t6_after_rst", 1, 0, 8'h5A);
    step("t6_after_pop", 0, 1, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
